soc_system_sw_ctrl: RTL and testbench

SOC_SYSTEM_SW_CTRL -- requirements
Module: soc_system_sw_ctrl

---
 rtl/soc_system_sw_ctrl.sv | 148 ++++++++++++++
 tb/tb_soc_system_sw_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_sw_ctrl.sv
// Two-channel switch debouncer with an Avalon-MM register interface.
// Each switch bit is synchronised, debounced against a programmable
// limit, and debounced changes are latched as maskable interrupt edges.
module soc_system_sw_ctrl #(
  parameter int              DB_W     = 16,
  parameter logic [DB_W-1:0] DB_RESET = 16'd50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [1:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic {IDLE, COUNT} db_state_t;

  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      stable;
  logic [1:0]      edge_set;
  logic [1:0]      edge_clr;
  logic [1:0]      edge_cap;
  logic [1:0]      irq_mask;
  logic [DB_W-1:0] limit;
  logic            wr_en;
  logic            unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign edge_clr     = (wr_en && address == 2'd3) ? writedata[1:0] : 2'b00;
  assign unused_wdata = ^writedata[31:DB_W];

  // Two-flop synchroniser on the raw switch inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_db
    db_state_t       state;
    db_state_t       state_nxt;
    logic [DB_W-1:0] cnt;
    logic [DB_W-1:0] cnt_nxt;
    logic [DB_W:0]   cnt_inc;
    logic            stable_q;
    logic            stable_nxt;
    logic            commit;

    // Per-bit debounce state, counter and stable value.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state    <= IDLE;
        cnt      <= '0;
        stable_q <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        stable_q <= stable_nxt;
      end
    end

    // Next-state logic. IDLE holds cnt at zero, so cnt_inc there is 1 and
    // the same commit test gives the limit 0/1 bypass without a special case.
    always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      stable_nxt = stable_q;
      commit     = 1'b0;
      cnt_inc    = {1'b0, cnt} + {{DB_W{1'b0}}, 1'b1};
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (sync2[b] != stable_q) begin
            if (cnt_inc >= {1'b0, limit}) begin
              stable_nxt = sync2[b];
              commit     = 1'b1;
            end else begin
              cnt_nxt   = cnt_inc[DB_W-1:0];
              state_nxt = COUNT;
            end
          end
        end
        COUNT: begin
          if (sync2[b] == stable_q) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (cnt_inc >= {1'b0, limit}) begin
            stable_nxt = sync2[b];
            commit     = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt = (&cnt) ? cnt : cnt_inc[DB_W-1:0];
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end

    assign stable[b]   = stable_q;
    assign edge_set[b] = commit;
  end

  // Writable configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit    <= DB_RESET;
      irq_mask <= '0;
    end else if (wr_en) begin
      if (address == 2'd1) limit    <= writedata[DB_W-1:0];
      if (address == 2'd2) irq_mask <= writedata[1:0];
    end
  end

  // Edge capture: write-1-to-clear, a new edge in the same cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~edge_clr) | edge_set;
  end

  // Registered read mux, zero-extended.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= {30'd0, stable};
        2'd1:    readdata <= {{(32-DB_W){1'b0}}, limit};
        2'd2:    readdata <= {30'd0, irq_mask};
        default: readdata <= {30'd0, edge_cap};
      endcase
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_soc_system_sw_ctrl.sv
// Self-checking bench: register-map vector table, directed debounce
// sequences and randomized traffic against a behavioural model.
module tb_soc_system_sw_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int vectors;
  int miscompares;

  soc_system_sw_ctrl #(.DB_W(16), .DB_RESET(16'd50000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: sync is in_port seen two edges late; a bit's stable
  // value flips once sync has disagreed with it for `limit` edges in a row.
  logic [1:0]  ms1, ms2, mstable, mmask, medge;
  logic [15:0] mlimit;
  logic [31:0] mrd;
  int          run [2];

  task automatic model_reset();
    ms1 = '0; ms2 = '0; mstable = '0; mmask = '0; medge = '0;
    mlimit = 16'd50000; mrd = '0; run[0] = 0; run[1] = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance model from pre-edge state, then compare after edge.
  task automatic step(input bit chk);
    logic [1:0]  sync, nstable, set, clr;
    logic [31:0] rd_n;
    sync = ms2; nstable = mstable; set = '0; clr = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync[b] != mstable[b]) begin
        run[b]++;
        if (run[b] >= int'(mlimit)) begin
          nstable[b] = sync[b]; set[b] = 1'b1; run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
    end
    case (address)
      2'd0:    rd_n = {30'd0, mstable};
      2'd1:    rd_n = {16'd0, mlimit};
      2'd2:    rd_n = {30'd0, mmask};
      default: rd_n = {30'd0, medge};
    endcase
    if (chipselect && !write_n) begin
      if (address == 2'd1) mlimit = writedata[15:0];
      if (address == 2'd2) mmask  = writedata[1:0];
      if (address == 2'd3) clr    = writedata[1:0];
    end
    medge = (medge & ~clr) | set;
    mstable = nstable; ms2 = ms1; ms1 = in_port; mrd = rd_n;
    @(posedge clk); #1;
    if (chk) begin
      check("model_rd", readdata, mrd);
      check("model_irq", {31'd0, irq}, {31'd0, |(medge & mmask)});
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl [13];

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();

    tbl[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h0,    1'b0};
    tbl[1]  = '{2'd1, 1'b0, 1'b1, 32'h0,        32'hC350, 1'b0};
    tbl[2]  = '{2'd1, 1'b1, 1'b0, 32'hFFFF0007, 32'hC350, 1'b0};
    tbl[3]  = '{2'd1, 1'b0, 1'b1, 32'h0,        32'h7,    1'b0};
    tbl[4]  = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,    1'b0};
    tbl[5]  = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h3,    1'b0};
    tbl[6]  = '{2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,    1'b0};
    tbl[7]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h0,    1'b0};
    tbl[8]  = '{2'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,    1'b0};
    tbl[9]  = '{2'd3, 1'b0, 1'b1, 32'h0,        32'h0,    1'b0};
    tbl[10] = '{2'd1, 1'b0, 1'b0, 32'h9,        32'h7,    1'b0};
    tbl[11] = '{2'd1, 1'b1, 1'b1, 32'h9,        32'h7,    1'b0};
    tbl[12] = '{2'd1, 1'b0, 1'b1, 32'h0,        32'h7,    1'b0};

    #3;
    check("reset_rd", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Register map
    for (int i = 0; i < 13; i++) begin
      address = tbl[i].addr; chipselect = tbl[i].cs;
      write_n = tbl[i].wn; writedata = tbl[i].wd;
      step(0);
      check("tbl_rd", readdata, tbl[i].rd);
      check("tbl_irq", {31'd0, irq}, {31'd0, tbl[i].irq});
    end
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // Limit 4, bit0 rise: stable at edge 6, visible on readdata at edge 7
    wr(2'd1, 32'd4); wr(2'd2, 32'd0);
    address = 2'd0; in_port = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (k == 6) check("rise_early", readdata, 32'h0);
      if (k == 7) check("rise_stable", readdata, 32'h1);
    end
    address = 2'd3; step(1);
    check("rise_edge", readdata, 32'h1);

    // Three-cycle glitch is rejected
    in_port = 2'b00; address = 2'd0;
    repeat (10) step(1);
    wr(2'd3, 32'h3); wr(2'd2, 32'h3);
    address = 2'd0; in_port = 2'b01;
    repeat (3) step(1);
    in_port = 2'b00;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("glitch_stable", readdata, 32'h0);
      check("glitch_irq", {31'd0, irq}, 32'h0);
    end
    address = 2'd3; step(1);
    check("glitch_edge", readdata, 32'h0);

    // Mask bit1, clear, and clear colliding with a new edge
    wr(2'd2, 32'h2);
    address = 2'd0; in_port = 2'b10;
    repeat (7) step(1);
    check("irq_set", {31'd0, irq}, 32'h1);
    wr(2'd3, 32'h2);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    in_port = 2'b00;
    repeat (5) step(1);
    wr(2'd3, 32'h2);
    check("set_wins_irq", {31'd0, irq}, 32'h1);
    address = 2'd3; step(1);
    check("set_wins_edge", readdata, 32'h2);

    // Limit 0 bypass, bit1 toggling every 3 cycles
    wr(2'd1, 32'd0); wr(2'd3, 32'h3);
    for (int t = 0; t < 8; t++) begin
      in_port[1] = ~in_port[1];
      address = 2'(t);
      repeat (3) step(1);
    end

    // Limit lowered below the running count commits on the next edge
    wr(2'd1, 32'd100);
    in_port = 2'b00; address = 2'd0;
    repeat (6) step(1);
    in_port = 2'b01;
    repeat (62) step(1);
    wr(2'd1, 32'd50);
    address = 2'd0; step(1);
    check("lower_limit_pre", readdata, 32'h0);
    step(1);
    check("lower_limit_commit", readdata, 32'h1);

    // Reset during COUNT
    wr(2'd1, 32'd4);
    in_port = 2'b00;
    repeat (4) step(1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midreset_rd", readdata, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    address = 2'd1; step(1);
    check("post_reset_limit", readdata, 32'hC350);
    address = 2'd3; step(1);
    check("post_reset_edge", readdata, 32'h0);
    address = 2'd0; step(1);
    check("post_reset_stable", readdata, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) in_port[$urandom_range(0, 1)] ^= 1'b1;
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
        writedata = $urandom;
        if (address == 2'd1) writedata[15:0] = 16'($urandom_range(0, 6));
      end
      step(1);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
